multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 128 ++++++++++++
 tb/tb_multi_timer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel countdown timer with a shared prescaler.
// Per channel: load/cancel strobes, pause hold, one-shot or periodic mode.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load          per-channel load strobe
//   load_value    per-channel start value, channel i at [i*WIDTH +: WIDTH]
//   mode          per-channel mode latched at load (0 one-shot, 1 periodic)
//   pause         per-channel level hold
//   cancel        per-channel abort strobe
//   count         per-channel registered count, same packing as load_value
//   busy          channel in RUN or PAUSED
//   expired       channel in EXPIRED
//   done          one-clock pulse when a channel reaches zero
module multi_timer #(
   parameter int WIDTH    = 19,
   parameter int CHANNELS = 4,
   parameter int PRESCALE = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_value,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS-1:0]       pause,
   input  logic [CHANNELS-1:0]       cancel,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       expired,
   output logic [CHANNELS-1:0]       done
);

   // Bit 1 is the busy flag; EXPIRED is the only state with 01.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      EXPIRED = 2'b01,
      RUN     = 2'b10,
      PAUSED  = 2'b11
   } state_t;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [PW-1:0]    psc_q;
   logic             tick;

   state_t           st_q   [CHANNELS];
   logic [WIDTH-1:0] cnt_q  [CHANNELS];
   logic [WIDTH-1:0] rld_q  [CHANNELS];
   logic [CHANNELS-1:0] mode_q;
   logic [CHANNELS-1:0] done_q;

   assign tick = (psc_q == PMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
      end else if (tick) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
         done_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
            rld_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            done_q[i] <= 1'b0;
            if (cancel[i]) begin
               st_q[i]  <= IDLE;
               cnt_q[i] <= '0;
            end else if (load[i]) begin
               mode_q[i] <= mode[i];
               rld_q[i]  <= load_value[i*WIDTH +: WIDTH];
               if (load_value[i*WIDTH +: WIDTH] == '0) begin
                  // Zero-length interval expires at once.
                  st_q[i]   <= EXPIRED;
                  cnt_q[i]  <= '0;
                  done_q[i] <= 1'b1;
               end else begin
                  st_q[i]  <= RUN;
                  cnt_q[i] <= load_value[i*WIDTH +: WIDTH];
               end
            end else begin
               unique case (st_q[i])
                  RUN, PAUSED: begin
                     // Pause wins over a tick; leaving pause
                     // applies that cycle's tick.
                     st_q[i] <= pause[i] ? PAUSED : RUN;
                     if (!pause[i] && tick) begin
                        if (cnt_q[i] == ONE) begin
                           done_q[i] <= 1'b1;
                           if (mode_q[i]) begin
                              cnt_q[i] <= rld_q[i];
                           end else begin
                              cnt_q[i] <= '0;
                              st_q[i]  <= EXPIRED;
                           end
                        end else begin
                           cnt_q[i] <= cnt_q[i] - ONE;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign count[g*WIDTH +: WIDTH] = cnt_q[g];
      assign busy[g]    = st_q[g][1];
      assign expired[g] = (st_q[g] == EXPIRED);
   end

   assign done = done_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer.
// Checks reset, one-shot, periodic, pause, retrigger, cancel, prescale.
module tb_multi_timer;

   localparam int W = 19;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [C-1:0]   load = '0;
   logic [C*W-1:0] lv = '0;
   logic [C-1:0]   mode = '0;
   logic [C-1:0]   pause = '0;
   logic [C-1:0]   cancel = '0;
   logic [C*W-1:0] count;
   logic [C-1:0]   busy;
   logic [C-1:0]   expired;
   logic [C-1:0]   done;

   logic         l4 = 1'b0;
   logic [W-1:0] lv4 = '0;
   logic         m4 = 1'b0;
   logic         p4 = 1'b0;
   logic         c4 = 1'b0;
   logic [W-1:0] cnt4;
   logic         busy4;
   logic         exp4;
   logic         done4;

   int n_asrt = 0;
   int n_fail = 0;

   multi_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE(1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .load_value(lv),
      .mode(mode), .pause(pause), .cancel(cancel), .count(count),
      .busy(busy), .expired(expired), .done(done)
   );

   multi_timer #(.WIDTH(W), .CHANNELS(1), .PRESCALE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .load(l4), .load_value(lv4),
      .mode(m4), .pause(p4), .cancel(c4), .count(cnt4),
      .busy(busy4), .expired(exp4), .done(done4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int i);
      return 32'(count[i*W +: W]);
   endfunction

   task automatic set_lv(input int i, input int v);
      lv[i*W +: W] = W'(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      logic [31:0] prev;
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_exp", 32'(expired), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      #20 rst_n = 1'b1;
      step();

      // one-shot 5 on ch0
      load[0] = 1'b1; set_lv(0, 5); mode[0] = 1'b0;
      step();
      load[0] = 1'b0;
      chk("os_cnt5", cnt(0), 32'd5);
      chk("os_busy", 32'(busy[0]), 32'd1);
      for (int j = 4; j >= 1; j--) begin
         step();
         chk("os_cnt", cnt(0), 32'(j));
         chk("os_nodone", 32'(done[0]), 32'd0);
      end
      step();
      chk("os_cnt0", cnt(0), 32'd0);
      chk("os_done", 32'(done[0]), 32'd1);
      chk("os_exp", 32'(expired[0]), 32'd1);
      chk("os_idle", 32'(busy[0]), 32'd0);
      step();
      chk("os_done_clr", 32'(done[0]), 32'd0);
      chk("os_exp_hold", 32'(expired[0]), 32'd1);

      // periodic 3 on ch1
      load[1] = 1'b1; set_lv(1, 3); mode[1] = 1'b1;
      step();
      load[1] = 1'b0;
      chk("per_cnt3", cnt(1), 32'd3);
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("per_cnt", cnt(1), 32'(3 - (k % 3)));
         chk("per_done", 32'(done[1]), 32'((k % 3) == 0));
         chk("per_noexp", 32'(expired[1]), 32'd0);
      end

      // ch2 load 10, pause 4 cycles at 7
      load[2] = 1'b1; set_lv(2, 10); mode[2] = 1'b0;
      step();
      load[2] = 1'b0;
      chk("pz_cnt10", cnt(2), 32'd10);
      step(); step(); step();
      chk("pz_cnt7", cnt(2), 32'd7);
      pause[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("pz_hold", cnt(2), 32'd7);
         chk("pz_busy", 32'(busy[2]), 32'd1);
      end
      pause[2] = 1'b0;
      for (int j = 6; j >= 1; j--) begin
         step();
         chk("pz_cnt", cnt(2), 32'(j));
         chk("pz_nodone", 32'(done[2]), 32'd0);
      end
      step();
      chk("pz_done", 32'(done[2]), 32'd1);
      chk("pz_exp", 32'(expired[2]), 32'd1);

      // ch0 load 4, retrigger 6 at 2; ch3 load 0
      load[0] = 1'b1; set_lv(0, 4); mode[0] = 1'b0;
      step();
      load[0] = 1'b0;
      chk("rt_cnt4", cnt(0), 32'd4);
      chk("rt_exp_clr", 32'(expired[0]), 32'd0);
      step(); step();
      chk("rt_cnt2", cnt(0), 32'd2);
      load[0] = 1'b1; set_lv(0, 6);
      load[3] = 1'b1; set_lv(3, 0);
      step();
      load = '0;
      chk("rt_cnt6", cnt(0), 32'd6);
      chk("z_done", 32'(done[3]), 32'd1);
      chk("z_exp", 32'(expired[3]), 32'd1);
      chk("z_busy", 32'(busy[3]), 32'd0);
      for (int j = 5; j >= 1; j--) begin
         step();
         chk("rt_cnt", cnt(0), 32'(j));
         chk("rt_nodone", 32'(done[0]), 32'd0);
      end
      chk("z_done_clr", 32'(done[3]), 32'd0);
      chk("z_exp_hold", 32'(expired[3]), 32'd1);
      step();
      chk("rt_done", 32'(done[0]), 32'd1);

      // load coincident with terminal tick on ch2
      load[2] = 1'b1; set_lv(2, 1); mode[2] = 1'b0;
      step();
      chk("lt_cnt1", cnt(2), 32'd1);
      set_lv(2, 2);
      step();
      load[2] = 1'b0;
      chk("lt_cnt2", cnt(2), 32'd2);
      chk("lt_nodone", 32'(done[2]), 32'd0);
      step();
      chk("lt_cnt", cnt(2), 32'd1);
      step();
      chk("lt_done", 32'(done[2]), 32'd1);

      // cancel with load on ch1, then reset mid-count
      cancel[1] = 1'b1; load[1] = 1'b1; set_lv(1, 7);
      step();
      cancel[1] = 1'b0; load[1] = 1'b0;
      chk("cn_cnt", cnt(1), 32'd0);
      chk("cn_busy", 32'(busy[1]), 32'd0);
      chk("cn_exp", 32'(expired[1]), 32'd0);
      chk("cn_done", 32'(done[1]), 32'd0);
      load = 4'b0101; set_lv(0, 8); set_lv(2, 8);
      step();
      load = '0;
      step();
      chk("mid_cnt", cnt(0), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_exp", 32'(expired), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      step();
      #3 rst_n = 1'b1;
      step();
      chk("rr_count", 32'(count), 32'd0);
      chk("rr_done", 32'(done), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);

      // prescale 4
      l4 = 1'b1; lv4 = W'(2);
      step();
      l4 = 1'b0;
      chk("p4_cnt2", 32'(cnt4), 32'd2);
      chk("p4_busy", 32'(busy4), 32'd1);
      prev = 32'(cnt4);
      lat = 99;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("p4_step", prev - 32'(cnt4) <= 1 ? 32'd1 : 32'd0, 32'd1);
         prev = 32'(cnt4);
         if (done4) begin
            lat = k;
            break;
         end
      end
      chk("p4_lat_ok", (lat >= 5 && lat <= 8) ? 32'd1 : 32'd0, 32'd1);
      chk("p4_exp", 32'(exp4), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
